sample_iter_ctrl: RTL and testbench

// Sequencer in front of the sample-test stage. Accepts one bounding-boxed triangle at a time,

---
 rtl/sample_iter_ctrl_pkg.sv | 25 ++
 rtl/samp_lane_gen.sv | 36 +++
 rtl/sample_iter_ctrl.sv | 130 +++++++++++++
 tb/tb_sample_iter_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_iter_ctrl_pkg.sv
// Shared types and helpers for the sample iteration sequencer.
// Holds the walk state encoding, the box index constants and the subsample step decode.
package sample_iter_ctrl_pkg;

   typedef enum logic {
      WAIT = 1'b0,
      TEST = 1'b1
   } state_t;

   localparam int LL = 0;
   localparam int UR = 1;
   localparam int X  = 0;
   localparam int Y  = 1;

   // One-hot subsample code to step shift: step = 1 << (RADIX - shift).
   function automatic int step_shift(input logic [3:0] sub_sample);
      case (sub_sample)
         4'b0100: step_shift = 1;
         4'b0010: step_shift = 2;
         4'b0001: step_shift = 3;
         default: step_shift = 0;
      endcase
   endfunction

endpackage

// File: rtl/samp_lane_gen.sv
// Lane x positions, lane valids and the next group start from the current walk position.
// Purely combinational; no latency and no flow control of its own.
module samp_lane_gen
   import sample_iter_ctrl_pkg::*;
#(
   parameter int SIGFIG = 24,
   parameter int SAMPS  = 4
) (
   input  logic signed [SIGFIG-1:0]  cur_x,
   input  logic signed [SIGFIG-1:0]  cur_y,
   input  logic signed [SIGFIG-1:0]  step,
   input  logic signed [SIGFIG-1:0]  ur_x,
   input  logic signed [SIGFIG-1:0]  ur_y,
   output logic [SAMPS-1:0][SIGFIG-1:0] lane_x,
   output logic [SAMPS-1:0]          lane_vld,
   output logic signed [SIGFIG-1:0]  next_x
);

   logic signed [SIGFIG-1:0] lx [SAMPS+1];

   // Running sum instead of k*step; the extra entry is the next group's start.
   always_comb begin
      lane_x   = '0;
      lane_vld = '0;
      lx[0]    = cur_x;
      for (int k = 1; k <= SAMPS; k++) begin
         lx[k] = lx[k-1] + step;
      end
      for (int k = 0; k < SAMPS; k++) begin
         lane_x[k]   = lx[k];
         lane_vld[k] = (lx[k] <= ur_x) && (cur_y <= ur_y);
      end
      next_x = lx[SAMPS];
   end

endmodule

// File: rtl/sample_iter_ctrl.sv
// Walks one bounding box per triangle in subsample steps, SAMPS lanes per cycle along +x.
// First group one edge after accept; halt_R13H held for the whole walk; halt_RnnnnH freezes everything.
module sample_iter_ctrl
   import sample_iter_ctrl_pkg::*;
#(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3,
   parameter int SAMPS  = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
   input  logic [COLORS-1:0][SIGFIG-1:0]          color_R13U,
   input  logic [1:0][1:0][SIGFIG-1:0]            box_R13S,
   input  logic                                   validTri_R13H,
   input  logic [3:0]                             subSample_RnnnnU,
   input  logic                                   halt_RnnnnH,
   output logic                                   halt_R13H,
   output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
   output logic [COLORS-1:0][SIGFIG-1:0]          color_R14U,
   output logic [1:0][SAMPS-1:0][SIGFIG-1:0]      sample_R14S,
   output logic [SAMPS-1:0]                       validSamp_R14H
);

   state_t state, state_nxt;
   logic   accept;

   logic signed [SIGFIG-1:0] ll_x, ur_x, ur_y, step;
   logic signed [SIGFIG-1:0] cur_x, cur_y, cur_x_nxt, cur_y_nxt;
   logic signed [SIGFIG-1:0] y_inc, next_x, step_in;
   logic [SAMPS-1:0][SIGFIG-1:0] lane_x;
   logic [SAMPS-1:0]             lane_vld;

   assign step_in = SIGFIG'(1) << (RADIX - step_shift(subSample_RnnnnU));

   samp_lane_gen #(
      .SIGFIG (SIGFIG),
      .SAMPS  (SAMPS)
   ) u_lane_gen (
      .cur_x    (cur_x),
      .cur_y    (cur_y),
      .step     (step),
      .ur_x     (ur_x),
      .ur_y     (ur_y),
      .lane_x   (lane_x),
      .lane_vld (lane_vld),
      .next_x   (next_x)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= WAIT;
      end else if (!halt_RnnnnH) begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      halt_R13H = 1'b0;
      cur_x_nxt = cur_x;
      cur_y_nxt = cur_y;
      y_inc     = cur_y + step;
      case (state)
         WAIT: begin
            if (validTri_R13H) begin
               accept    = 1'b1;
               state_nxt = TEST;
            end
         end
         TEST: begin
            // Stays high through the last group so the next accept lands after WAIT is reached.
            halt_R13H = 1'b1;
            if (next_x <= ur_x) begin
               cur_x_nxt = next_x;
            end else begin
               cur_x_nxt = ll_x;
               cur_y_nxt = y_inc;
               if (y_inc > ur_y) begin
                  state_nxt = WAIT;
               end
            end
         end
         default: state_nxt = WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tri_R14S       <= '0;
         color_R14U     <= '0;
         sample_R14S    <= '0;
         validSamp_R14H <= '0;
         ll_x           <= '0;
         ur_x           <= '0;
         ur_y           <= '0;
         step           <= '0;
         cur_x          <= '0;
         cur_y          <= '0;
      end else if (!halt_RnnnnH) begin
         if (accept) begin
            tri_R14S   <= tri_R13S;
            color_R14U <= color_R13U;
            ll_x       <= box_R13S[LL][X];
            ur_x       <= box_R13S[UR][X];
            ur_y       <= box_R13S[UR][Y];
            step       <= step_in;
            cur_x      <= box_R13S[LL][X];
            cur_y      <= box_R13S[LL][Y];
         end else begin
            cur_x <= cur_x_nxt;
            cur_y <= cur_y_nxt;
         end
         if (state == TEST) begin
            sample_R14S[X] <= lane_x;
            for (int k = 0; k < SAMPS; k++) begin
               sample_R14S[Y][k] <= cur_y;
            end
            validSamp_R14H <= lane_vld;
         end else begin
            validSamp_R14H <= '0;
         end
      end
   end

endmodule

// File: tb/tb_sample_iter_ctrl.sv
// Directed bench for sample_iter_ctrl: expected groups are queued by the stimulus
// and a negedge monitor pops and compares each group the DUT hands downstream.
module tb_sample_iter_ctrl;

   localparam int SIGFIG = 24;
   localparam int RADIX  = 10;
   localparam int VERTS  = 3;
   localparam int AXIS   = 3;
   localparam int COLORS = 3;
   localparam int SAMPS  = 4;

   logic                                   clk;
   logic                                   rst;
   logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
   logic [COLORS-1:0][SIGFIG-1:0]          color_R13U;
   logic [1:0][1:0][SIGFIG-1:0]            box_R13S;
   logic                                   validTri_R13H;
   logic [3:0]                             subSample_RnnnnU;
   logic                                   halt_RnnnnH;
   logic                                   halt_R13H;
   logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
   logic [COLORS-1:0][SIGFIG-1:0]          color_R14U;
   logic [1:0][SAMPS-1:0][SIGFIG-1:0]      sample_R14S;
   logic [SAMPS-1:0]                       validSamp_R14H;

   typedef struct {
      logic [SAMPS-1:0][SIGFIG-1:0] x;
      logic [SIGFIG-1:0]            y;
      logic [SAMPS-1:0]             vld;
   } grp_t;

   grp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   hcnt   = 0;
   int   npop   = 0;

   logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_exp;
   logic [COLORS-1:0][SIGFIG-1:0]          color_exp;

   sample_iter_ctrl #(
      .SIGFIG (SIGFIG),
      .RADIX  (RADIX),
      .VERTS  (VERTS),
      .AXIS   (AXIS),
      .COLORS (COLORS),
      .SAMPS  (SAMPS)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .tri_R13S         (tri_R13S),
      .color_R13U       (color_R13U),
      .box_R13S         (box_R13S),
      .validTri_R13H    (validTri_R13H),
      .subSample_RnnnnU (subSample_RnnnnU),
      .halt_RnnnnH      (halt_RnnnnH),
      .halt_R13H        (halt_R13H),
      .tri_R14S         (tri_R14S),
      .color_R14U       (color_R14U),
      .sample_R14S      (sample_R14S),
      .validSamp_R14H   (validSamp_R14H)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic push_grp(input int x0, input int st, input int y, input logic [3:0] vld);
      grp_t g;
      for (int k = 0; k < SAMPS; k++) begin
         g.x[k] = SIGFIG'(x0 + k * st);
      end
      g.y   = SIGFIG'(y);
      g.vld = vld;
      exp_q.push_back(g);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_box(input int llx, input int lly, input int urx, input int ury,
                           input logic [3:0] ss);
      box_R13S[0][0]   = SIGFIG'(llx);
      box_R13S[0][1]   = SIGFIG'(lly);
      box_R13S[1][0]   = SIGFIG'(urx);
      box_R13S[1][1]   = SIGFIG'(ury);
      subSample_RnnnnU = ss;
      validTri_R13H    = 1'b1;
      hcnt             = 0;
      npop             = 0;
      tick();
      validTri_R13H    = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int i;
      for (i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!halt_R13H) break;
      end
      if (i == 200) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: halt_R13H still 1 after %0d cycles, required 0", name, i);
      end
      tick();
   endtask

   // Downstream consumes a group in any cycle it is visible with halt_RnnnnH low.
   initial begin
      forever begin
         @(negedge clk);
         if (halt_R13H) hcnt++;
         if (|validSamp_R14H) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_group: got valid %b, required no group", validSamp_R14H);
            end else begin
               chk(halt_RnnnnH ? "frozen_x" : "grp_x", 256'(sample_R14S[0]), 256'(exp_q[0].x));
               chk(halt_RnnnnH ? "frozen_y" : "grp_y", 256'(sample_R14S[1]), 256'({SAMPS{exp_q[0].y}}));
               chk(halt_RnnnnH ? "frozen_vld" : "grp_vld", 256'(validSamp_R14H), 256'(exp_q[0].vld));
               if (!halt_RnnnnH) begin
                  void'(exp_q.pop_front());
                  npop++;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst              = 1'b0;
      validTri_R13H    = 1'b0;
      halt_RnnnnH      = 1'b0;
      subSample_RnnnnU = 4'b1000;
      box_R13S         = '0;
      for (int v = 0; v < VERTS; v++) begin
         for (int a = 0; a < AXIS; a++) begin
            tri_R13S[v][a] = SIGFIG'(v * 16 + a + 1);
            tri_exp[v][a]  = SIGFIG'(v * 16 + a + 1);
         end
      end
      for (int c = 0; c < COLORS; c++) begin
         color_R13U[c] = SIGFIG'(24'h00A000 + c);
         color_exp[c]  = SIGFIG'(24'h00A000 + c);
      end

      // 1) reset
      tick();
      tick();
      rst = 1'b1;
      chk("rst_valid", 256'(validSamp_R14H), 256'(0));
      chk("rst_halt", 256'(halt_R13H), 256'(0));
      chk("rst_sample", 256'(sample_R14S), 256'(0));
      chk("rst_tri", 256'(tri_R14S), 256'(0));

      // 2) 1spp, 4x2 pixel box
      push_grp(0, 1024, 0, 4'b1111);
      push_grp(0, 1024, 1024, 4'b1111);
      send_box(0, 0, 3072, 1024, 4'b1000);
      chk("t2_tri", 256'(tri_R14S), 256'(tri_exp));
      chk("t2_color", 256'(color_R14U), 256'(color_exp));
      wait_idle("t2");
      chk("t2_halt_cycles", 256'(hcnt), 256'(2));
      chk("t2_groups", 256'(npop), 256'(2));
      chk("t2_queue", 256'(exp_q.size()), 256'(0));

      // 3) 4spp, box narrower than one group; subSample change mid-box is ignored
      push_grp(0, 512, 0, 4'b0011);
      push_grp(0, 512, 512, 4'b0011);
      send_box(0, 0, 512, 512, 4'b0100);
      subSample_RnnnnU = 4'b1000;
      wait_idle("t3");
      chk("t3_halt_cycles", 256'(hcnt), 256'(2));
      chk("t3_groups", 256'(npop), 256'(2));
      chk("t3_queue", 256'(exp_q.size()), 256'(0));

      // 4) degenerate box
      push_grp(5120, 1024, 7168, 4'b0001);
      send_box(5120, 7168, 5120, 7168, 4'b1000);
      wait_idle("t4");
      chk("t4_halt_cycles", 256'(hcnt), 256'(1));
      chk("t4_groups", 256'(npop), 256'(1));
      chk("t4_queue", 256'(exp_q.size()), 256'(0));

      // 5) downstream halt for 3 cycles while the first group is visible
      for (int r = 0; r < 4; r++) push_grp(0, 1024, r * 1024, 4'b1111);
      send_box(0, 0, 3072, 3072, 4'b1000);
      tick();
      halt_RnnnnH = 1'b1;
      tick();
      tick();
      tick();
      halt_RnnnnH = 1'b0;
      wait_idle("t5");
      chk("t5_halt_cycles", 256'(hcnt), 256'(7));
      chk("t5_groups", 256'(npop), 256'(4));
      chk("t5_queue", 256'(exp_q.size()), 256'(0));

      // 6) reset while the second group of a 4-group walk is visible
      push_grp(0, 1024, 0, 4'b1111);
      push_grp(0, 1024, 1024, 4'b1111);
      send_box(0, 0, 3072, 3072, 4'b1000);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("t6_rst_valid", 256'(validSamp_R14H), 256'(0));
      chk("t6_rst_halt", 256'(halt_R13H), 256'(0));
      chk("t6_rst_sample", 256'(sample_R14S), 256'(0));
      chk("t6_groups", 256'(npop), 256'(2));
      rst = 1'b1;
      push_grp(0, 1024, 0, 4'b0001);
      send_box(0, 0, 0, 0, 4'b1000);
      chk("t6_accept_halt", 256'(halt_R13H), 256'(1));
      wait_idle("t6");
      chk("t6_halt_cycles", 256'(hcnt), 256'(1));
      chk("t6_queue", 256'(exp_q.size()), 256'(0));

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
